instr_fetch: RTL and testbench

- Instruction fetch stage for the RV32I core. Sits directly upstream of the instruction decoder.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Holds each returned instruction in an output buffer and presents it with its PC to decode over a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from execute, discarding any stale fetch.

---
 rtl/rv32_pkg.sv | 16 +
 rtl/instr_fetch.sv | 129 ++++++++++++
 tb/tb_instr_fetch.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions used by the fetch stage.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and
// presents one buffered instruction at a time to decode over valid/ready.
module instr_fetch
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] RESET_PC_WORD = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            mem_req_q, mem_req_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;

    logic [XLEN-1:0] redirect_word;
    logic            unused_redirect_lsbs;

    assign redirect_word        = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // The memory address is the PC register itself, so it only moves when a
    // new transaction starts; in DRAIN the PC is left on the in-flight address.
    assign mem_req    = mem_req_q;
    assign mem_addr   = pc_q;
    assign inst_valid = inst_valid_q;
    assign instr_out  = instr_q;
    assign pc_out     = pc_out_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        mem_req_d    = mem_req_q;
        inst_valid_d = inst_valid_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;

        unique case (state_q)
            StIdle: begin
                mem_req_d = 1'b1;
                state_d   = StFetch;
            end

            StFetch: begin
                if (mem_ack) begin
                    if (redirect_valid) begin
                        // Response is stale; reissue at the new target right away.
                        pc_d = redirect_word;
                    end else begin
                        instr_d      = mem_rdata;
                        pc_out_d     = pc_q;
                        inst_valid_d = 1'b1;
                        mem_req_d    = 1'b0;
                        state_d      = StHold;
                    end
                end else if (redirect_valid) begin
                    target_d = redirect_word;
                    state_d  = StDrain;
                end
            end

            StDrain: begin
                if (mem_ack) begin
                    pc_d    = redirect_valid ? redirect_word : target_q;
                    state_d = StFetch;
                end else if (redirect_valid) begin
                    target_d = redirect_word;
                end
            end

            StHold: begin
                // A redirect wins over a consume: the held instruction is dropped.
                if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    pc_d         = redirect_word;
                    mem_req_d    = 1'b1;
                    state_d      = StFetch;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    pc_d         = pc_q + 32'd4;
                    mem_req_d    = 1'b1;
                    state_d      = StFetch;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC_WORD;
            target_q     <= '0;
            mem_req_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            instr_q      <= NOP;
            pc_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            mem_req_q    <= mem_req_d;
            inst_valid_q <= inst_valid_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run,
// all checked against a transaction-level model of the fetch protocol.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    int n_vec = 0;
    int n_err = 0;

    // Protocol-level reference model.
    bit          m_busy;     // a memory read is in flight
    logic [31:0] m_addr;     // address of the in-flight read
    bit          m_stale;    // a redirect arrived while the read was in flight
    logic [31:0] m_want;     // address the next new read must use
    bit          m_show;     // an instruction must be on offer to decode
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    bit          m_due;      // a new read starts at the coming edge

    instr_fetch #(
        .RESET_PC(RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0; m_addr = '0; m_stale = 0; m_want = RST_PC;
        m_show = 0; m_instr = NOP_W; m_pc = '0; m_due = 0;
    endtask

    // Apply one cycle of inputs at a negedge, advance the model, return at the next negedge.
    task automatic step(input bit ack, input bit rdy, input bit rv, input logic [31:0] rpc);
        logic [31:0] data;
        data = $urandom;
        mem_ack = ack; mem_rdata = data; inst_ready = rdy;
        redirect_valid = rv; redirect_pc = rpc;
        if (m_busy) begin
            if (rv) begin m_stale = 1; m_want = rpc & 32'hFFFF_FFFC; end
            if (ack) begin
                m_busy = 0;
                if (m_stale) m_due = 1;
                else begin m_show = 1; m_instr = data; m_pc = m_addr; end
            end
        end else if (m_show) begin
            if (rv) begin m_show = 0; m_want = rpc & 32'hFFFF_FFFC; m_due = 1; end
            else if (rdy) begin m_show = 0; m_want = m_pc + 32'd4; m_due = 1; end
        end else begin
            m_due = 1;  // just out of reset: first read goes to the reset PC
        end
        @(negedge clk);
        if (m_due) begin m_due = 0; m_busy = 1; m_addr = m_want; m_stale = 0; end
        mem_ack = 0; redirect_valid = 0; inst_ready = 0;
    endtask

    task automatic release_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", mem_req); end
        n_vec++; if (mem_addr !== RST_PC) begin n_err++; $display("FAIL reset_addr got %h want %h", mem_addr, RST_PC); end
        n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", inst_valid); end
        n_vec++; if (instr_out !== NOP_W) begin n_err++; $display("FAIL reset_instr got %h want %h", instr_out, NOP_W); end
        n_vec++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc_out got %h want 0", pc_out); end
        release_reset();
        step(0, 0, 0, '0);
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== RST_PC) begin
            n_err++; $display("FAIL first_req got %b/%h want 1/%h", mem_req, mem_addr, RST_PC); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (mem_req !== 1'b1 || mem_addr !== RST_PC + 32'(4 * i)) begin
                n_err++; $display("FAIL stream_addr%0d got %b/%h want 1/%h", i, mem_req, mem_addr,
                                  RST_PC + 32'(4 * i)); end
            n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL stream_novalid%0d got %b want 0", i, inst_valid); end
            step(1, 1, 0, '0);
            n_vec++; if (inst_valid !== 1'b1 || mem_req !== 1'b0) begin
                n_err++; $display("FAIL stream_valid%0d got v=%b r=%b want v=1 r=0", i, inst_valid, mem_req); end
            n_vec++; if (instr_out !== m_instr || pc_out !== RST_PC + 32'(4 * i)) begin
                n_err++; $display("FAIL stream_data%0d got %h@%h want %h@%h", i, instr_out, pc_out, m_instr,
                                  RST_PC + 32'(4 * i)); end
            step(0, 1, 0, '0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_i, held_p;
        step(1, 0, 0, '0);
        held_i = m_instr; held_p = m_pc;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, '0);
            n_vec++; if (inst_valid !== 1'b1 || mem_req !== 1'b0 || instr_out !== held_i || pc_out !== held_p) begin
                n_err++; $display("FAIL stall%0d got v=%b r=%b %h@%h want v=1 r=0 %h@%h", i, inst_valid, mem_req,
                                  instr_out, pc_out, held_i, held_p); end
        end
        step(0, 1, 0, '0);
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== held_p + 32'd4) begin
            n_err++; $display("FAIL stall_release got %b/%h want 1/%h", mem_req, mem_addr, held_p + 32'd4); end
    endtask

    task automatic test_redirect_drain();
        logic [31:0] old;
        old = mem_addr;
        step(0, 1, 1, 32'h200);
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (mem_req !== 1'b1 || mem_addr !== old || inst_valid !== 1'b0) begin
                n_err++; $display("FAIL drain_hold%0d got r=%b %h v=%b want r=1 %h v=0", i, mem_req, mem_addr,
                                  inst_valid, old); end
            if (i < 2) step(0, 1, 0, '0);
        end
        step(1, 1, 0, '0);
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_target got r=%b %h v=%b want r=1 200 v=0", mem_req, mem_addr, inst_valid); end
    endtask

    task automatic test_redirect_hold();
        step(1, 0, 0, '0);
        step(0, 1, 1, 32'h300);
        n_vec++; if (inst_valid !== 1'b0 || mem_addr !== 32'h300 || mem_req !== 1'b1) begin
            n_err++; $display("FAIL hold_redirect got v=%b r=%b %h want v=0 r=1 300", inst_valid, mem_req, mem_addr); end
        step(1, 0, 0, '0);
        step(0, 1, 1, 32'h303);
        n_vec++; if (inst_valid !== 1'b0 || mem_addr !== 32'h300) begin
            n_err++; $display("FAIL redirect_align got v=%b %h want v=0 300", inst_valid, mem_addr); end
    endtask

    task automatic test_double_redirect();
        step(0, 0, 1, 32'h400);
        step(0, 0, 1, 32'h500);
        n_vec++; if (mem_addr !== 32'h300) begin n_err++; $display("FAIL dbl_hold got %h want 300", mem_addr); end
        step(1, 0, 0, '0);
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h500 || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL dbl_target got r=%b %h v=%b want r=1 500 v=0", mem_req, mem_addr, inst_valid); end
    endtask

    task automatic test_async_reset();
        #2 rst = 1'b1;
        #1;
        n_vec++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || mem_addr !== RST_PC) begin
            n_err++; $display("FAIL async_rst got r=%b v=%b %h want r=0 v=0 %h", mem_req, inst_valid, mem_addr, RST_PC); end
        release_reset();
        step(0, 0, 0, '0);
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== RST_PC) begin
            n_err++; $display("FAIL restart got %b/%h want 1/%h", mem_req, mem_addr, RST_PC); end
    endtask

    task automatic test_wrap();
        step(1, 0, 1, 32'hFFFF_FFFC);
        n_vec++; if (mem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_setup got %h want fffffffc", mem_addr); end
        step(1, 0, 0, '0);
        n_vec++; if (pc_out !== 32'hFFFF_FFFC || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_pc got %h v=%b want fffffffc v=1", pc_out, inst_valid); end
        step(0, 1, 0, '0);
        n_vec++; if (mem_addr !== 32'h0 || mem_req !== 1'b1) begin
            n_err++; $display("FAIL wrap_next got %h r=%b want 0 r=1", mem_addr, mem_req); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            n_vec++; if (mem_req !== 1'(m_busy)) begin
                n_err++; $display("FAIL rnd_req%0d got %b want %b", i, mem_req, m_busy); end
            if (m_busy) begin
                n_vec++; if (mem_addr !== m_addr) begin
                    n_err++; $display("FAIL rnd_addr%0d got %h want %h", i, mem_addr, m_addr); end
            end
            n_vec++; if (inst_valid !== 1'(m_show)) begin
                n_err++; $display("FAIL rnd_valid%0d got %b want %b", i, inst_valid, m_show); end
            if (m_show) begin
                n_vec++; if (instr_out !== m_instr || pc_out !== m_pc) begin
                    n_err++; $display("FAIL rnd_data%0d got %h@%h want %h@%h", i, instr_out, pc_out, m_instr, m_pc); end
            end
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                 $urandom);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drain();
        test_redirect_hold();
        test_double_redirect();
        test_async_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
